// File: rtl/inst_encoder.sv
// RV32I R/I-type ALU instruction word generator feeding a 2-entry output FIFO.
// Illegal micro-ops are consumed, dropped and counted.
module inst_encoder #(
   parameter int          AW        = 8,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          restart,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [3:0]    in_aluop,
   input  logic          in_imm_fmt,
   input  logic [4:0]    in_rd,
   input  logic [4:0]    in_rs1,
   input  logic [4:0]    in_rs2,
   input  logic [11:0]   in_imm,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [31:0]   out_inst,
   output logic [AW-1:0] out_addr,
   output logic          err,
   output logic [7:0]    err_cnt
);

   localparam logic [AW-1:0] BASE = AW'(BASE_ADDR);

   logic [1:0]    r_cnt;
   logic          r_head, r_tail;
   logic [31:0]   r_inst [2];
   logic [AW-1:0] r_waddr [2];
   logic [AW-1:0] r_addr_q;
   logic          r_err;
   logic [7:0]    r_err_cnt;

   logic [2:0]    w_funct3;
   logic [6:0]    w_funct7;
   logic          w_legal;
   logic [31:0]   w_inst;
   logic          w_accept, w_push, w_pop, w_illegal;

   // Inverse of the control decoder's ALUop table; SUB has no I-type form.
   always_comb begin
      w_funct3 = 3'b000;
      w_legal  = 1'b0;
      case (in_aluop)
         4'b0000: begin w_funct3 = 3'b111; w_legal = 1'b1; end
         4'b0001: begin w_funct3 = 3'b110; w_legal = 1'b1; end
         4'b0010: begin w_funct3 = 3'b000; w_legal = 1'b1; end
         4'b0110: begin w_funct3 = 3'b000; w_legal = !in_imm_fmt; end
         default: ;
      endcase
   end

   assign w_funct7 = (in_aluop == 4'b0110) ? 7'b0100000 : 7'b0000000;
   assign w_inst   = in_imm_fmt ? {in_imm, in_rs1, w_funct3, in_rd, 7'b0010011}
                                : {w_funct7, in_rs2, in_rs1, w_funct3, in_rd, 7'b0110011};

   assign in_ready  = (r_cnt != 2'd2);
   assign out_valid = (r_cnt != 2'd0);
   assign out_inst  = r_inst[r_head];
   assign out_addr  = r_waddr[r_head];
   assign err       = r_err;
   assign err_cnt   = r_err_cnt;

   // A request accepted alongside restart is discarded without error.
   assign w_accept  = in_valid && in_ready;
   assign w_push    = w_accept && w_legal && !restart;
   assign w_illegal = w_accept && !w_legal && !restart;
   assign w_pop     = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt     <= 2'd0;
         r_head    <= 1'b0;
         r_tail    <= 1'b0;
         r_addr_q  <= BASE;
         r_err     <= 1'b0;
         r_err_cnt <= 8'd0;
         for (int i = 0; i < 2; i++) begin
            r_inst[i]  <= 32'd0;
            r_waddr[i] <= BASE;
         end
      end else begin
         r_err <= w_illegal;
         if (w_illegal && r_err_cnt != 8'hFF)
            r_err_cnt <= r_err_cnt + 8'd1;
         if (restart) begin
            r_cnt    <= 2'd0;
            r_head   <= 1'b0;
            r_tail   <= 1'b0;
            r_addr_q <= BASE;
         end else begin
            if (w_push) begin
               r_inst[r_tail]  <= w_inst;
               r_waddr[r_tail] <= r_addr_q;
               r_tail          <= ~r_tail;
               r_addr_q        <= r_addr_q + 1'b1;
            end
            if (w_pop)
               r_head <= ~r_head;
            case ({w_push, w_pop})
               2'b10:   r_cnt <= r_cnt + 2'd1;
               2'b01:   r_cnt <= r_cnt - 2'd1;
               default: ;
            endcase
         end
      end
   end

endmodule
